// File: rtl/sigma_np_pkg.sv
// sigma_np_pkg
//   Shared definitions for the sigma_np window accumulator.
//   - mode_e       : MODE_BLOCK (disjoint N-sample windows) / MODE_SLIDE (running N-sample sum)
//   - acc_w()      : accumulator width for a given sample width and log2 window length
//   - sm2tc()      : sign-magnitude sample to two's-complement integer (-0 maps to 0)
package sigma_np_pkg;

  typedef enum logic {
    MODE_BLOCK = 1'b0,
    MODE_SLIDE = 1'b1
  } mode_e;

  // The sum of N samples of magnitude < 2**(in_w-1) needs log2n extra bits
  // on top of the sample width, so this never overflows.
  function automatic int acc_w(input int in_w, input int log2n);
    return in_w + log2n;
  endfunction

  // MSB of the in_w-bit field is the sign, the remaining bits the magnitude.
  function automatic int sm2tc(input logic [31:0] sm, input int in_w);
    int mag;
    mag = int'(sm & ((32'd1 << (in_w - 1)) - 32'd1));
    return sm[in_w-1] ? -mag : mag;
  endfunction

endpackage

// File: rtl/sigma_np_dline.sv
// sigma_np_dline
//   N-entry circular delay line (N = 2**LOG2N) of W-bit words.
//   On each write strobe the new word replaces the entry at the pointer and the
//   pointer advances; that entry is also the oldest one, so rd_data shows the
//   word about to be overwritten.
// Ports
//   clk      in   system clock
//   res      in   asynchronous active-high reset (pointer only)
//   clr      in   synchronous pointer clear
//   we       in   write strobe (one word per strobe)
//   wr_data  in   W  word to store
//   rd_data  out  W  oldest entry, registered read of the pointer address
module sigma_np_dline #(
  parameter int W     = 12,
  parameter int LOG2N = 4
) (
  input  logic         clk,
  input  logic         res,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data
);

  localparam int N = 1 << LOG2N;

  logic [W-1:0]     mem [0:N-1];
  logic [LOG2N-1:0] ptr_reg;

  // Storage has no reset so it maps onto block RAM. The read is registered
  // from the current pointer every cycle: strobes come from a rising-edge
  // detector and are therefore at least two cycles apart, so in the strobe
  // cycle rd_data already holds the entry at the (unchanged) pointer.
  // After a pointer clear the first reads may be stale, but the caller masks
  // the oldest value until the window has been refilled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[ptr_reg] <= wr_data;
    end
    rd_data <= mem[ptr_reg];
  end

  // Pointer wraps naturally because N is a power of two.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ptr_reg <= '0;
    end else if (clr) begin
      ptr_reg <= '0;
    end else if (we) begin
      ptr_reg <= ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sigma_np.sv
// sigma_np
//   N-point accumulator for sign-magnitude samples taken on the rising edge of
//   a slow strobe. Block mode emits one sum per disjoint group of N samples;
//   sliding mode emits the running sum of the last N samples once the window
//   has filled.
//   Optional feature macro: SIGMA_NP_MEAN_EN adds mean_out = data_out >>> LOG2N.
// Ports
//   clk       in   system clock
//   res       in   asynchronous active-high reset
//   clr       in   synchronous flush of window state
//   mode      in   0 = block, 1 = sliding
//   data_in   in   IN_W   sign-magnitude sample
//   syn_in    in   sample strobe, rising edge takes a sample
//   data_out  out  ACC_W  two's-complement window sum
//   syn_out   out  one-cycle pulse when data_out is updated
//   win_full  out  sliding mode: N samples held since last flush
//   mean_out  out  IN_W+1 window mean (only with SIGMA_NP_MEAN_EN)
module sigma_np
  import sigma_np_pkg::*;
#(
  parameter  int IN_W  = 8,
  parameter  int LOG2N = 4,
  localparam int ACC_W = acc_w(IN_W, LOG2N)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             mode,
  input  logic [IN_W-1:0]  data_in,
  input  logic             syn_in,
  output logic [ACC_W-1:0] data_out,
  output logic             syn_out,
  output logic             win_full
`ifdef SIGMA_NP_MEAN_EN
  ,
  output logic [IN_W:0]    mean_out
`endif
);

  localparam int               N         = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_LAST  = LOG2N'(N - 1);
  localparam logic [LOG2N:0]   FILL_FULL = (LOG2N + 1)'(N);

  logic                    syn_d_reg;
  mode_e                   mode_reg;
  logic [LOG2N-1:0]        cnt_reg;
  logic [LOG2N:0]          fill_reg;
  logic signed [ACC_W-1:0] sum_reg;

  logic                    pulse;
  logic                    flush;
  logic                    take;
  logic                    full;
  logic signed [ACC_W-1:0] d;
  logic signed [ACC_W-1:0] oldest;
  logic signed [ACC_W-1:0] sum_add;
  logic signed [ACC_W-1:0] sum_slide;
  logic [LOG2N:0]          fill_next;
  logic                    load_block;
  logic                    load_slide;
  logic                    load_out;
  logic signed [ACC_W-1:0] out_next;

  assign pulse = syn_in & ~syn_d_reg;
  // A mode change flushes exactly like clr; a pulse in a flush cycle is dropped.
  assign flush = clr | (mode != mode_reg);
  assign take  = pulse & ~flush;

  assign d         = ACC_W'(sm2tc(32'(data_in), IN_W));
  assign full      = (fill_reg == FILL_FULL);
  assign sum_add   = sum_reg + d;
  // Until the window is full the delay line may hold stale words; mask them.
  assign sum_slide = sum_add - (full ? oldest : '0);
  assign fill_next = full ? fill_reg : fill_reg + 1'b1;

  assign load_block = take & (mode_reg == MODE_BLOCK) & (cnt_reg == CNT_LAST);
  assign load_slide = take & (mode_reg == MODE_SLIDE) & (fill_next == FILL_FULL);
  assign load_out   = load_block | load_slide;
  assign out_next   = (mode_reg == MODE_BLOCK) ? sum_add : sum_slide;

  sigma_np_dline #(
    .W     (ACC_W),
    .LOG2N (LOG2N)
  ) u_dline (
    .clk     (clk),
    .res     (res),
    .clr     (flush),
    .we      (take & (mode_reg == MODE_SLIDE)),
    .wr_data (d),
    .rd_data (oldest)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      syn_d_reg <= 1'b0;
      mode_reg  <= MODE_BLOCK;
      cnt_reg   <= '0;
      fill_reg  <= '0;
      sum_reg   <= '0;
      data_out  <= '0;
      syn_out   <= 1'b0;
      win_full  <= 1'b0;
    end else begin
      syn_d_reg <= syn_in;
      mode_reg  <= mode_e'(mode);
      syn_out   <= load_out;
      if (load_out) begin
        data_out <= out_next;
      end
      if (flush) begin
        cnt_reg  <= '0;
        fill_reg <= '0;
        sum_reg  <= '0;
        win_full <= 1'b0;
      end else if (take) begin
        if (mode_reg == MODE_BLOCK) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            sum_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            sum_reg <= sum_add;
          end
        end else begin
          sum_reg  <= sum_slide;
          fill_reg <= fill_next;
          if (fill_next == FILL_FULL) begin
            win_full <= 1'b1;
          end
        end
      end
    end
  end

`ifdef SIGMA_NP_MEAN_EN
  // Arithmetic shift rounds toward -inf; the result always fits IN_W+1 bits.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      mean_out <= '0;
    end else if (load_out) begin
      mean_out <= (IN_W + 1)'(out_next >>> LOG2N);
    end
  end
`else
  // No mean output in this build.
`endif

endmodule

// File: tb/tb_sigma_np.sv
// tb_sigma_np
//   Directed bench for sigma_np with default parameters (IN_W=8, LOG2N=4).
//   Build with +define+SIGMA_NP_MEAN_EN to also check mean_out.
module tb_sigma_np;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        clr = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        syn_in = 1'b0;
  logic [11:0] data_out;
  logic        syn_out;
  logic        win_full;
`ifdef SIGMA_NP_MEAN_EN
  logic [8:0]  mean_out;
`endif

  int tests = 0;
  int fails = 0;
  int syn_cnt = 0;

  sigma_np dut (
    .clk      (clk),
    .res      (res),
    .clr      (clr),
    .mode     (mode),
    .data_in  (data_in),
    .syn_in   (syn_in),
    .data_out (data_out),
    .syn_out  (syn_out),
    .win_full (win_full)
`ifdef SIGMA_NP_MEAN_EN
    ,
    .mean_out (mean_out)
`endif
  );

  always #5 clk = ~clk;

  // Counts every cycle syn_out is high, so a wide pulse shows as extra counts.
  always @(negedge clk) begin
    if (syn_out === 1'b1) syn_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One sample: strobe rises at a falling edge, the pulse is taken at the next
  // rising edge and the result is sampled at the falling edge after that.
  logic        s_syn;
  logic [11:0] s_out;
  task automatic send(input logic [7:0] v, input logic with_clr);
    @(negedge clk);
    data_in = v;
    syn_in  = 1'b1;
    clr     = with_clr;
    @(negedge clk);
    s_syn  = syn_out;
    s_out  = data_out;
    syn_in = 1'b0;
    clr    = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_n(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send(v, 1'b0);
  endtask

  int base;

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_syn_out", 32'(syn_out), 32'h0);
    check("rst_win_full", 32'(win_full), 32'h0);
    res = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- 1: block, ones ----------------
    send_n(8'h01, 15);
    check("t1_no_syn_before_16", 32'(syn_cnt), 32'd0);
    send(8'h01, 1'b0);
    check("t1_syn_16th", 32'(s_syn), 32'h1);
    check("t1_sum", 32'(s_out), 32'd16);
`ifdef SIGMA_NP_MEAN_EN
    check("t1_mean", 32'(mean_out), 32'h1);
`endif
    $display("[TB] t1 block ones window1 data_out=%0d", s_out);
    send_n(8'h01, 16);
    check("t1_sum2", 32'(s_out), 32'd16);
    check("t1_syn_count", 32'(syn_cnt), 32'd2);
    $display("[TB] t1 block ones window2 data_out=%0d", s_out);

    // ---------------- 2: block, negative and -0 ----------------
    send_n(8'h85, 16);
    check("t2_neg5", 32'(s_out), 32'hFB0);
`ifdef SIGMA_NP_MEAN_EN
    check("t2_mean", 32'(mean_out), 32'h1FB);
`endif
    $display("[TB] t2 block -5 x16 data_out=%h", s_out);
    send_n(8'h80, 16);
    check("t2_negzero", 32'(s_out), 32'h000);
    $display("[TB] t2 block -0 x16 data_out=%h", s_out);

    // ---------------- 3: block, extremes ----------------
    send_n(8'h7F, 16);
    check("t3_max", 32'(s_out), 32'h7F0);
    $display("[TB] t3 block +127 x16 data_out=%h", s_out);
    send_n(8'hFF, 16);
    check("t3_min", 32'(s_out), 32'h810);
    check("t3_syn_count", 32'(syn_cnt), 32'd6);
    $display("[TB] t3 block -127 x16 data_out=%h", s_out);

    // ---------------- 4: sliding ramp ----------------
    @(negedge clk);
    mode = 1'b1;
    repeat (2) @(negedge clk);
    base = syn_cnt;
    for (int k = 1; k <= 15; k++) send(8'(k), 1'b0);
    check("t4_no_syn_before_16", 32'(syn_cnt - base), 32'd0);
    check("t4_not_full_15", 32'(win_full), 32'h0);
    send(8'd16, 1'b0);
    check("t4_syn_16th", 32'(s_syn), 32'h1);
    check("t4_sum16", 32'(s_out), 32'd136);
    check("t4_full_16", 32'(win_full), 32'h1);
    $display("[TB] t4 slide sample 16 data_out=%0d win_full=%0d", s_out, win_full);
    for (int k = 17; k <= 20; k++) begin
      send(8'(k), 1'b0);
      check("t4_slide_sum", 32'(s_out), 32'(136 + 16 * (k - 16)));
      check("t4_slide_syn", 32'(s_syn), 32'h1);
      $display("[TB] t4 slide sample %0d data_out=%0d", k, s_out);
    end
    check("t4_syn_count", 32'(syn_cnt - base), 32'd5);

    // ---------------- 5: flushes ----------------
    @(negedge clk);
    mode = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_mode_flush_full", 32'(win_full), 32'h0);
    base = syn_cnt;
    send_n(8'h01, 7);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t5_clr_holds_out", 32'(data_out), 32'd200);
    send_n(8'h01, 16);
    check("t5_after_clr", 32'(s_out), 32'd16);
    check("t5_clr_syn_count", 32'(syn_cnt - base), 32'd1);
    $display("[TB] t5 clr then 16 ones data_out=%0d", s_out);

    base = syn_cnt;
    send(8'h05, 1'b1);               // dropped: clr wins
    send_n(8'h01, 15);
    check("t5_clr_pulse_dropped", 32'(syn_cnt - base), 32'd0);
    send(8'h01, 1'b0);
    check("t5_clr_pulse_sum", 32'(s_out), 32'd16);
    $display("[TB] t5 clr on pulse, 16 ones data_out=%0d", s_out);

    base = syn_cnt;
    send_n(8'h01, 5);
    @(negedge clk);
    mode = 1'b1;
    @(negedge clk);
    mode = 1'b0;
    repeat (2) @(negedge clk);
    send_n(8'h01, 11);
    check("t5_toggle_no_syn", 32'(syn_cnt - base), 32'd0);
    send_n(8'h01, 5);
    check("t5_toggle_sum", 32'(s_out), 32'd16);
    check("t5_toggle_syn_count", 32'(syn_cnt - base), 32'd1);
    $display("[TB] t5 mode toggle, refill data_out=%0d", s_out);

    // ---------------- 6: async reset, held strobe ----------------
    send_n(8'h01, 5);
    @(negedge clk);
    res = 1'b1;
    #1;
    check("t6_res_data_out", 32'(data_out), 32'h0);
    check("t6_res_syn_out", 32'(syn_out), 32'h0);
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    base = syn_cnt;
    data_in = 8'h01;
    syn_in  = 1'b1;
    repeat (300) @(negedge clk);
    syn_in = 1'b0;
    @(negedge clk);
    send_n(8'h01, 14);
    check("t6_held_no_syn", 32'(syn_cnt - base), 32'd0);
    send(8'h01, 1'b0);
    check("t6_held_syn", 32'(s_syn), 32'h1);
    check("t6_held_sum", 32'(s_out), 32'd16);
    $display("[TB] t6 held strobe + 15 samples data_out=%0d", s_out);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
